// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit
//   Control-and-hazard unit for a 5-stage RISC-V pipeline.
//
//   Decodes the Decode-stage opcode and carries the control bundle through
//   the D->E, E->M and M->W pipeline registers. When the bundle enters
//   Execute as a bubble, it is all zeros. The unit resolves branches in
//   Execute and produces the stall, flush and forwarding selects used by
//   the datapath.
//
//   Parameters
//     EXT_OPS      1: decode lui/auipc/jalr, 0: treat them as illegal
//     FULL_BRANCH  1: all six branch conditions, 0: beq only
//
//   Ports
//     clk, reset_n                  clock (rising edge), async active-low reset
//     opD, funct3D                  Decode opcode / funct3
//     Rs1D, Rs2D, RdD               Decode register addresses
//     ZeroE, LtE, LtuE              Execute ALU flags (eq, signed lt, unsigned lt)
//     ImmSrcD, IllegalD             combinational Decode outputs
//     ALUSrcAE, ALUSrcBE, ALUOpE,
//     funct3E, PCSrcE, IllegalE     Execute-stage outputs
//     MemWriteM                     Memory-stage write enable
//     RegWriteW, ResultSrcW         Writeback-stage controls
//     ForwardAE, ForwardBE          operand forward selects
//     StallF, StallD, FlushD, FlushE hazard controls
module ctrl_pipe_unit #(
  parameter bit EXT_OPS     = 1'b1,
  parameter bit FULL_BRANCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opD,
  input  logic [2:0] funct3D,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       ZeroE,
  input  logic       LtE,
  input  logic       LtuE,
  output logic [2:0] ImmSrcD,
  output logic       IllegalD,
  output logic [1:0] ALUSrcAE,
  output logic       ALUSrcBE,
  output logic [1:0] ALUOpE,
  output logic [2:0] funct3E,
  output logic [1:0] PCSrcE,
  output logic       IllegalE,
  output logic       MemWriteM,
  output logic       RegWriteW,
  output logic [1:0] ResultSrcW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
  } ctrl_t;

  ctrl_t      ctrl_d_s;
  logic [2:0] imm_src_d_s;
  logic       illegal_d_s;
  logic       branch_ok_s;

  ctrl_t      de_ctrl_r;
  logic       de_illegal_r;
  logic [2:0] de_funct3_r;
  logic [4:0] de_rs1_r;
  logic [4:0] de_rs2_r;
  logic [4:0] de_rd_r;

  logic       em_reg_write_r;
  logic       em_mem_write_r;
  logic [1:0] em_result_src_r;
  logic [4:0] em_rd_r;

  logic       mw_reg_write_r;
  logic [1:0] mw_result_src_r;
  logic [4:0] mw_rd_r;

  logic       taken_s;
  logic [1:0] pc_src_s;
  logic       lw_stall_s;
  logic       flush_d_s;
  logic       flush_e_s;

  // Forward select for one source operand; M has priority over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic rw_m, input logic [4:0] rd_m,
                                         input logic rw_w, input logic [4:0] rd_w);
    logic [1:0] sel;
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Without the full branch set, only beq (funct3 000) is legal; with it, 010/011 are the holes.
  assign branch_ok_s = FULL_BRANCH ? (funct3D[2:1] != 2'b01) : (funct3D == 3'b000);

  // Decode the D-stage opcode into the control bundle; unsupported encodings give all zeros.
  always_comb begin
    ctrl_d_s    = '0;
    imm_src_d_s = 3'b000;
    illegal_d_s = 1'b0;
    case (opD)
      7'b0000011: begin
        ctrl_d_s.reg_write  = 1'b1;
        ctrl_d_s.alu_src_b  = 1'b1;
        ctrl_d_s.result_src = 2'b01;
      end
      7'b0100011: begin
        imm_src_d_s        = 3'b001;
        ctrl_d_s.alu_src_b = 1'b1;
        ctrl_d_s.mem_write = 1'b1;
      end
      7'b0110011: begin
        ctrl_d_s.reg_write = 1'b1;
        ctrl_d_s.alu_op    = 2'b10;
      end
      7'b1100011: begin
        if (branch_ok_s) begin
          imm_src_d_s     = 3'b010;
          ctrl_d_s.branch = 1'b1;
          ctrl_d_s.alu_op = 2'b01;
        end else begin
          illegal_d_s = 1'b1;
        end
      end
      7'b0010011: begin
        ctrl_d_s.reg_write = 1'b1;
        ctrl_d_s.alu_src_b = 1'b1;
        ctrl_d_s.alu_op    = 2'b10;
      end
      7'b1101111: begin
        ctrl_d_s.reg_write  = 1'b1;
        imm_src_d_s         = 3'b011;
        ctrl_d_s.result_src = 2'b10;
        ctrl_d_s.jump       = 1'b1;
      end
      7'b0110111: begin
        if (EXT_OPS) begin
          ctrl_d_s.reg_write = 1'b1;
          imm_src_d_s        = 3'b100;
          ctrl_d_s.alu_src_a = 2'b10;
          ctrl_d_s.alu_src_b = 1'b1;
        end else begin
          illegal_d_s = 1'b1;
        end
      end
      7'b0010111: begin
        if (EXT_OPS) begin
          ctrl_d_s.reg_write = 1'b1;
          imm_src_d_s        = 3'b100;
          ctrl_d_s.alu_src_a = 2'b01;
          ctrl_d_s.alu_src_b = 1'b1;
        end else begin
          illegal_d_s = 1'b1;
        end
      end
      7'b1100111: begin
        if (EXT_OPS && (funct3D == 3'b000)) begin
          ctrl_d_s.reg_write  = 1'b1;
          ctrl_d_s.alu_src_b  = 1'b1;
          ctrl_d_s.result_src = 2'b10;
          ctrl_d_s.jalr       = 1'b1;
        end else begin
          illegal_d_s = 1'b1;
        end
      end
      default: begin
        illegal_d_s = 1'b1;
      end
    endcase
  end

  // D->E register: captures Decode every cycle, loads a bubble on FlushE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_ctrl_r    <= '0;
      de_illegal_r <= 1'b0;
      de_funct3_r  <= 3'b000;
      de_rs1_r     <= 5'd0;
      de_rs2_r     <= 5'd0;
      de_rd_r      <= 5'd0;
    end else if (flush_e_s) begin
      de_ctrl_r    <= '0;
      de_illegal_r <= 1'b0;
      de_funct3_r  <= 3'b000;
      de_rs1_r     <= 5'd0;
      de_rs2_r     <= 5'd0;
      de_rd_r      <= 5'd0;
    end else begin
      de_ctrl_r    <= ctrl_d_s;
      de_illegal_r <= illegal_d_s;
      de_funct3_r  <= funct3D;
      de_rs1_r     <= Rs1D;
      de_rs2_r     <= Rs2D;
      de_rd_r      <= RdD;
    end
  end

  // E->M and M->W registers: always advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      em_reg_write_r  <= 1'b0;
      em_mem_write_r  <= 1'b0;
      em_result_src_r <= 2'b00;
      em_rd_r         <= 5'd0;
      mw_reg_write_r  <= 1'b0;
      mw_result_src_r <= 2'b00;
      mw_rd_r         <= 5'd0;
    end else begin
      em_reg_write_r  <= de_ctrl_r.reg_write;
      em_mem_write_r  <= de_ctrl_r.mem_write;
      em_result_src_r <= de_ctrl_r.result_src;
      em_rd_r         <= de_rd_r;
      mw_reg_write_r  <= em_reg_write_r;
      mw_result_src_r <= em_result_src_r;
      mw_rd_r         <= em_rd_r;
    end
  end

  // Branch condition and next-PC select in Execute; jalr wins over jal/branch.
  always_comb begin
    taken_s = 1'b0;
    case (de_funct3_r)
      3'b000:  taken_s = ZeroE;
      3'b001:  taken_s = !ZeroE;
      3'b100:  taken_s = LtE;
      3'b101:  taken_s = !LtE;
      3'b110:  taken_s = LtuE;
      3'b111:  taken_s = !LtuE;
      default: taken_s = 1'b0;
    endcase
    if (de_ctrl_r.jalr) begin
      pc_src_s = 2'b10;
    end else if (de_ctrl_r.jump || (de_ctrl_r.branch && taken_s)) begin
      pc_src_s = 2'b01;
    end else begin
      pc_src_s = 2'b00;
    end
  end

  // Load-use stall compares Rs2D even for instructions that ignore rs2 (conservative).
  assign lw_stall_s = (de_ctrl_r.result_src == 2'b01) && (de_rd_r != 5'd0) &&
                      ((de_rd_r == Rs1D) || (de_rd_r == Rs2D));
  assign flush_d_s  = (pc_src_s != 2'b00);
  assign flush_e_s  = lw_stall_s || flush_d_s;

  assign ImmSrcD    = imm_src_d_s;
  assign IllegalD   = illegal_d_s;
  assign ALUSrcAE   = de_ctrl_r.alu_src_a;
  assign ALUSrcBE   = de_ctrl_r.alu_src_b;
  assign ALUOpE     = de_ctrl_r.alu_op;
  assign funct3E    = de_funct3_r;
  assign PCSrcE     = pc_src_s;
  assign IllegalE   = de_illegal_r;
  assign MemWriteM  = em_mem_write_r;
  assign RegWriteW  = mw_reg_write_r;
  assign ResultSrcW = mw_result_src_r;
  assign ForwardAE  = fwd_sel(de_rs1_r, em_reg_write_r, em_rd_r, mw_reg_write_r, mw_rd_r);
  assign ForwardBE  = fwd_sel(de_rs2_r, em_reg_write_r, em_rd_r, mw_reg_write_r, mw_rd_r);
  assign StallF     = lw_stall_s;
  assign StallD     = lw_stall_s;
  assign FlushD     = flush_d_s;
  assign FlushE     = flush_e_s;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit
//   Two instances: "full" (EXT_OPS=1, FULL_BRANCH=1) and "min" (both 0),
//   driven by the same Decode/flag stimulus. An instruction-slot model holds
//   the instruction in each of the E/M/W slots and derives every output from
//   the decode table and the hazard rules.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ZeroE, LtE, LtuE;

  logic [2:0] imm_src [2];
  logic       illegal_d [2];
  logic [1:0] alu_src_a [2];
  logic       alu_src_b [2];
  logic [1:0] alu_op [2];
  logic [2:0] funct3_e [2];
  logic [1:0] pc_src [2];
  logic       illegal_e [2];
  logic       mem_write_m [2];
  logic       reg_write_w [2];
  logic [1:0] result_src_w [2];
  logic [1:0] fwd_a [2];
  logic [1:0] fwd_b [2];
  logic       stall_f [2];
  logic       stall_d [2];
  logic       flush_d [2];
  logic       flush_e [2];

  ctrl_pipe_unit #(.EXT_OPS(1'b1), .FULL_BRANCH(1'b1)) u_full (
    .clk(clk), .reset_n(reset_n), .opD(opD), .funct3D(funct3D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(imm_src[0]), .IllegalD(illegal_d[0]), .ALUSrcAE(alu_src_a[0]),
    .ALUSrcBE(alu_src_b[0]), .ALUOpE(alu_op[0]), .funct3E(funct3_e[0]),
    .PCSrcE(pc_src[0]), .IllegalE(illegal_e[0]), .MemWriteM(mem_write_m[0]),
    .RegWriteW(reg_write_w[0]), .ResultSrcW(result_src_w[0]),
    .ForwardAE(fwd_a[0]), .ForwardBE(fwd_b[0]), .StallF(stall_f[0]),
    .StallD(stall_d[0]), .FlushD(flush_d[0]), .FlushE(flush_e[0])
  );

  ctrl_pipe_unit #(.EXT_OPS(1'b0), .FULL_BRANCH(1'b0)) u_min (
    .clk(clk), .reset_n(reset_n), .opD(opD), .funct3D(funct3D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(imm_src[1]), .IllegalD(illegal_d[1]), .ALUSrcAE(alu_src_a[1]),
    .ALUSrcBE(alu_src_b[1]), .ALUOpE(alu_op[1]), .funct3E(funct3_e[1]),
    .PCSrcE(pc_src[1]), .IllegalE(illegal_e[1]), .MemWriteM(mem_write_m[1]),
    .RegWriteW(reg_write_w[1]), .ResultSrcW(result_src_w[1]),
    .ForwardAE(fwd_a[1]), .ForwardBE(fwd_b[1]), .StallF(stall_f[1]),
    .StallD(stall_d[1]), .FlushD(flush_d[1]), .FlushE(flush_e[1])
  );

  always #5 clk = ~clk;

  // One instruction slot: table columns (RegWrite..Jalr), illegal flag, funct3, registers.
  typedef struct packed {
    logic       rw;
    logic [2:0] imm;
    logic [1:0] asa;
    logic       asb;
    logic       mw;
    logic [1:0] rsrc;
    logic       br;
    logic [1:0] aop;
    logic       j;
    logic       jr;
    logic       ill;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } slot_t;

  slot_t e_s [2];
  slot_t m_s [2];
  slot_t w_s [2];
  bit    ext_cfg  [2] = '{1'b1, 1'b0};
  bit    full_cfg [2] = '{1'b1, 1'b0};
  int    n_err = 0;
  int    n_chk = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decode table, written exactly as the rows RegWrite/ImmSrc/ALUSrcA/ALUSrcB/MemWrite/ResultSrc/Branch/ALUOp/Jump/Jalr.
  function automatic slot_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [4:0] rd, input bit ext, input bit full);
    logic [14:0] ctl;
    bit ok;
    ok = 1'b1;
    ctl = 15'd0;
    case (op)
      7'b0000011: ctl = {1'b1, 3'b000, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
      7'b0100011: ctl = {1'b0, 3'b001, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
      7'b0110011: ctl = {1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
      7'b1100011: begin
        ctl = {1'b0, 3'b010, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0};
        ok  = full ? !(f3 == 3'b010 || f3 == 3'b011) : (f3 == 3'b000);
      end
      7'b0010011: ctl = {1'b1, 3'b000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
      7'b1101111: ctl = {1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0};
      7'b0110111: begin
        ctl = {1'b1, 3'b100, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
        ok  = ext;
      end
      7'b0010111: begin
        ctl = {1'b1, 3'b100, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
        ok  = ext;
      end
      7'b1100111: begin
        ctl = {1'b1, 3'b000, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1};
        ok  = ext && (f3 == 3'b000);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) ctl = 15'd0;
    return slot_t'({ctl, ~ok, f3, r1, r2, rd});
  endfunction

  function automatic logic [1:0] ref_pcsrc(input slot_t e, input logic z, input logic lt, input logic ltu);
    bit taken;
    case (e.f3)
      3'b000: taken = z;
      3'b001: taken = !z;
      3'b100: taken = lt;
      3'b101: taken = !lt;
      3'b110: taken = ltu;
      3'b111: taken = !ltu;
      default: taken = 1'b0;
    endcase
    if (e.jr) return 2'b10;
    if (e.j || (e.br && taken)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_lwstall(input slot_t e, input logic [4:0] r1, input logic [4:0] r2);
    return (e.rsrc == 2'b01) && (e.rd != 5'd0) && ((e.rd == r1) || (e.rd == r2));
  endfunction

  function automatic logic [1:0] ref_fwd(input slot_t m, input slot_t w, input logic [4:0] rs);
    if (m.rw && m.rd != 5'd0 && m.rd == rs) return 2'b10;
    if (w.rw && w.rd != 5'd0 && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic string nm(input int k, input string f);
    return $sformatf("%s.%s", (k == 0) ? "full" : "min", f);
  endfunction

  task automatic check_outputs(input int k);
    slot_t d;
    logic [1:0] pc;
    logic ls;
    d  = ref_decode(opD, funct3D, Rs1D, Rs2D, RdD, ext_cfg[k], full_cfg[k]);
    pc = ref_pcsrc(e_s[k], ZeroE, LtE, LtuE);
    ls = ref_lwstall(e_s[k], Rs1D, Rs2D);
    check_eq(nm(k, "ImmSrcD"),    32'(imm_src[k]),      32'(d.imm));
    check_eq(nm(k, "IllegalD"),   32'(illegal_d[k]),    32'(d.ill));
    check_eq(nm(k, "ALUSrcAE"),   32'(alu_src_a[k]),    32'(e_s[k].asa));
    check_eq(nm(k, "ALUSrcBE"),   32'(alu_src_b[k]),    32'(e_s[k].asb));
    check_eq(nm(k, "ALUOpE"),     32'(alu_op[k]),       32'(e_s[k].aop));
    check_eq(nm(k, "funct3E"),    32'(funct3_e[k]),     32'(e_s[k].f3));
    check_eq(nm(k, "IllegalE"),   32'(illegal_e[k]),    32'(e_s[k].ill));
    check_eq(nm(k, "PCSrcE"),     32'(pc_src[k]),       32'(pc));
    check_eq(nm(k, "MemWriteM"),  32'(mem_write_m[k]),  32'(m_s[k].mw));
    check_eq(nm(k, "RegWriteW"),  32'(reg_write_w[k]),  32'(w_s[k].rw));
    check_eq(nm(k, "ResultSrcW"), 32'(result_src_w[k]), 32'(w_s[k].rsrc));
    check_eq(nm(k, "ForwardAE"),  32'(fwd_a[k]),        32'(ref_fwd(m_s[k], w_s[k], e_s[k].rs1)));
    check_eq(nm(k, "ForwardBE"),  32'(fwd_b[k]),        32'(ref_fwd(m_s[k], w_s[k], e_s[k].rs2)));
    check_eq(nm(k, "StallF"),     32'(stall_f[k]),      32'(ls));
    check_eq(nm(k, "StallD"),     32'(stall_d[k]),      32'(ls));
    check_eq(nm(k, "FlushD"),     32'(flush_d[k]),      32'(pc != 2'b00));
    check_eq(nm(k, "FlushE"),     32'(flush_e[k]),      32'(ls || (pc != 2'b00)));
  endtask

  // Drive Decode inputs after the falling edge, then compare both instances against the model.
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic z, input logic lt, input logic ltu);
    @(negedge clk);
    opD = op; funct3D = f3; Rs1D = r1; Rs2D = r2; RdD = rd;
    ZeroE = z; LtE = lt; LtuE = ltu;
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic filler();
    drive(7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Rising edge: instructions move one slot; a flush puts an empty slot into E.
  task automatic tick();
    slot_t d;
    logic fl;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      d  = ref_decode(opD, funct3D, Rs1D, Rs2D, RdD, ext_cfg[k], full_cfg[k]);
      fl = ref_lwstall(e_s[k], Rs1D, Rs2D) || (ref_pcsrc(e_s[k], ZeroE, LtE, LtuE) != 2'b00);
      w_s[k] = m_s[k];
      m_s[k] = e_s[k];
      e_s[k] = fl ? slot_t'(0) : d;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      e_s[k] = slot_t'(0); m_s[k] = slot_t'(0); w_s[k] = slot_t'(0);
    end
  endtask

  logic [6:0] op_tab [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                              7'b1101111, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};

  initial begin
    reset_n = 1'b0;
    opD = 7'b0110011; funct3D = 3'b000; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Load-use: lw x5 ; add x6,x5,x1
    drive(7'b0000011, 3'b010, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0); tick();
    drive(7'b0110011, 3'b000, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0);
    check_eq("lu.StallF", 32'(stall_f[0]), 32'd1);
    check_eq("lu.StallD", 32'(stall_d[0]), 32'd1);
    check_eq("lu.FlushE", 32'(flush_e[0]), 32'd1);
    tick();
    drive(7'b0110011, 3'b000, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0);
    check_eq("lu.StallF_released", 32'(stall_f[0]), 32'd0);
    tick();
    filler();
    check_eq("lu.ForwardAE", 32'(fwd_a[0]), 32'd1);
    tick();

    // Forwarding from M: add x3 ; sub x4,x3,x3
    drive(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0); tick();
    drive(7'b0110011, 3'b000, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0); tick();
    filler();
    check_eq("fw.ForwardAE", 32'(fwd_a[0]), 32'd2);
    check_eq("fw.ForwardBE", 32'(fwd_b[0]), 32'd2);
    tick();
    // rd = x0 never forwards
    drive(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(7'b0110011, 3'b000, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0); tick();
    filler();
    check_eq("x0.ForwardAE", 32'(fwd_a[0]), 32'd0);
    check_eq("x0.ForwardBE", 32'(fwd_b[0]), 32'd0);
    tick();

    // bne taken with ZeroE=0; bgeu not taken with LtuE=1
    drive(7'b1100011, 3'b001, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    filler();
    check_eq("bne.PCSrcE", 32'(pc_src[0]), 32'd1);
    check_eq("bne.FlushD", 32'(flush_d[0]), 32'd1);
    check_eq("bne.FlushE", 32'(flush_e[0]), 32'd1);
    tick();
    drive(7'b1100011, 3'b111, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check_eq("bgeu.PCSrcE", 32'(pc_src[0]), 32'd0);
    tick();

    // jalr x1,0(x2)
    drive(7'b1100111, 3'b000, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0); tick();
    filler();
    check_eq("jalr.PCSrcE", 32'(pc_src[0]), 32'd2);
    check_eq("jalr.ALUSrcAE", 32'(alu_src_a[0]), 32'd0);
    tick(); filler(); tick(); filler();
    check_eq("jalr.ResultSrcW", 32'(result_src_w[0]), 32'd2);
    tick();

    // lui / auipc; min instance rejects both
    drive(7'b0110111, 3'b000, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
    check_eq("lui.ImmSrcD", 32'(imm_src[0]), 32'd4);
    check_eq("lui.min.IllegalD", 32'(illegal_d[1]), 32'd1);
    tick();
    drive(7'b0010111, 3'b000, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
    check_eq("lui.ALUSrcAE", 32'(alu_src_a[0]), 32'd2);
    check_eq("lui.min.IllegalE", 32'(illegal_e[1]), 32'd1);
    check_eq("lui.min.ALUSrcAE", 32'(alu_src_a[1]), 32'd0);
    tick();
    drive(7'b1100011, 3'b100, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    check_eq("auipc.ALUSrcAE", 32'(alu_src_a[0]), 32'd1);
    check_eq("blt.min.IllegalD", 32'(illegal_d[1]), 32'd1);
    check_eq("blt.full.IllegalD", 32'(illegal_d[0]), 32'd0);
    tick();

    // Randomized stream with a small register pool so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      op = (($urandom_range(0, 15)) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 9)];
      drive(op, 3'($urandom), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    // Mid-cycle asynchronous reset, then R-type reaches W three cycles after Decode
    drive(7'b0000011, 3'b010, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    clear_model();
    #1;
    check_outputs(0);
    check_outputs(1);
    check_eq("rst.IllegalE", 32'(illegal_e[1]), 32'd0);
    @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    drive(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0); tick();
    filler(); tick();
    filler(); tick();
    filler();
    check_eq("rst.RegWriteW", 32'(reg_write_w[0]), 32'd1);
    check_eq("rst.ResultSrcW", 32'(result_src_w[0]), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control-and-hazard unit for the 5-stage RISC-V core. It decodes the Decode-stage opcode, extended with lui/auipc/jalr and all six branch conditions, and carries the control bundle through the E, M and W pipeline registers with bubble insertion. It also resolves branches in Execute and generates stall, flush and forwarding selects for the datapath.

## Interface
- EXT_OPS, 1: 1 decodes lui/auipc/jalr; 0 treats them as illegal.
- FULL_BRANCH, 1: 1 decodes beq/bne/blt/bge/bltu/bgeu; 0 decodes beq only, and other funct3 values are illegal.
- clk  in  1  clock; rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- opD  in  7  opcode of the instruction in Decode.
- funct3D  in  3  funct3 in Decode.
- Rs1D, Rs2D, RdD  in  5 each  register addresses in Decode.
- ZeroE, LtE, LtuE  in  1 each  ALU flags in Execute: equal, signed-less, unsigned-less.
- ImmSrcD  out  3  extender select: 000 I, 001 S, 010 B, 011 J, 100 U.
- IllegalD  out  1  Decode opcode/funct3 not supported.
- ALUSrcAE  out  2  ALU A operand: 00 rs1, 01 PC, 10 zero.
- ALUSrcBE  out  1  ALU B operand: 0 rs2, 1 imm.
- ALUOpE  out  2  ALU decoder class.
- funct3E  out  3  funct3 carried to Execute.
- PCSrcE  out  2  next-PC select: 00 PC+4, 01 PC+imm, 10 ALU result.
- IllegalE  out  1  registered IllegalD.
- MemWriteM  out  1  data-memory write enable.
- RegWriteW  out  1  register-file write enable.
- ResultSrcW  out  2  writeback select: 00 ALU, 01 mem, 10 PC+4.
- ForwardAE, ForwardBE  out  2 each  operand forward select: 00 regfile, 01 W result, 10 M ALU result.
- StallF, StallD, FlushD, FlushE  out  1 each  hazard controls.

## Operation
- Decode table, listed as RegWrite/ImmSrc/ALUSrcA/ALUSrcB/MemWrite/ResultSrc/Branch/ALUOp/Jump/Jalr:
  - lw 0000011: 1/000/00/1/0/01/0/00/0/0
  - sw 0100011: 0/001/00/1/1/00/0/00/0/0
  - R 0110011: 1/000/00/0/0/00/0/10/0/0
  - branch 1100011: 0/010/00/0/0/00/1/01/0/0
  - I-ALU 0010011: 1/000/00/1/0/00/0/10/0/0
  - jal 1101111: 1/011/00/0/0/10/0/00/1/0
  - lui 0110111: 1/100/10/1/0/00/0/00/0/0
  - auipc 0010111: 1/100/01/1/0/00/0/00/0/0
  - jalr 1100111 with funct3 000: 1/000/00/1/0/10/0/00/0/1
- Illegal opcode or funct3 (including branch funct3 010/011, and any jalr funct3 other than 000): all controls 0 and IllegalD=1.
- Pipeline registers:
  - The D→E register captures the control bundle, IllegalD, funct3D, Rs1D, Rs2D and RdD every cycle.
  - When FlushE=1, the D→E register loads all zeros instead (bubble).
  - The E→M and M→W registers always advance.
- Branch condition from funct3E:
  - 000: ZeroE
  - 001: !ZeroE
  - 100: LtE
  - 101: !LtE
  - 110: LtuE
  - 111: !LtuE
- PCSrcE: 10 if JalrE; else 01 if JumpE or (BranchE and taken); else 00.
- lwStall = (ResultSrcE==01) and (RdE≠0) and (RdE==Rs1D or RdE==Rs2D).
  - Rs2D is compared even when the instruction does not use rs2. This conservative stall is intentional.
- StallF = StallD = lwStall.
- FlushD = (PCSrcE≠00).
- FlushE = lwStall or FlushD.
- ForwardAE:
  - 10 if RegWriteM and RdM≠0 and RdM==Rs1E;
  - else 01 if RegWriteW and RdW≠0 and RdW==Rs1E;
  - else 00.
  - ForwardBE uses Rs2E with the same rules.
- Register x0 is never a forwarding or stall source.

## Timing
- ImmSrcD and IllegalD are combinational from the D-stage inputs.
- E-stage outputs are valid 1 cycle after Decode. MemWriteM follows 2 cycles after Decode, and RegWriteW/ResultSrcW follow 3 cycles after Decode.
- Hazard and forward outputs are combinational from registered E/M/W state and the D-stage inputs.
- A simultaneous lwStall and taken branch/jump gives StallF=StallD=1 and FlushD=FlushE=1. The flush overrides the stall in the datapath.
- Reset (reset_n low, asynchronous, including mid-operation): all pipeline registers clear immediately, so every E/M/W output and IllegalE is 0.
  - With the pipeline registers clear, StallF/StallD/FlushD/FlushE=0 and ForwardAE/BE=00.
  - ImmSrcD and IllegalD continue to follow opD/funct3D.
- A bubble carries RegWrite=0 and MemWrite=0, so it never writes state.

## Test plan
- Reset: reset_n=0 mid-stream → all registered outputs 0 within the same cycle; release → R-type 0110011 gives RegWriteW=1 and ResultSrcW=00 three cycles later.
- Load-use: lw x5 then add x6,x5,x1 → StallF=StallD=FlushE=1 for one cycle, then ForwardAE=01 for the add in E.
- Forwarding: add x3 then sub x4,x3,x3 → ForwardAE=ForwardBE=10; writing rd=x0 → ForwardAE=ForwardBE=00.
- Branches (FULL_BRANCH=1): bne with ZeroE=0 → PCSrcE=01 and FlushD=FlushE=1; bgeu with LtuE=1 → PCSrcE=00.
- jalr x1,0(x2) → PCSrcE=10, ALUSrcAE=00, ResultSrcW=10; lui → ImmSrcD=100, ALUSrcAE=10; auipc → ALUSrcAE=01.
- EXT_OPS=0 with lui, or FULL_BRANCH=0 with blt → IllegalD=1 and IllegalE=1 next cycle, all controls 0.
